emu_csr_sequencer: RTL and testbench

AXI-Lite master that drives the emulator control/status register (CSR) slave port from a stream of host commands. It converts WRITE, READ and POLL commands into AXI-Lite transactions and returns one response per command. It sits directly upstream of the emulator system's s_axilite port. Host software, or a bench command queue, can therefore script sequences such as: set step count, start, poll for trigger, halt, run DMA, poll DMA status.

---
 rtl/emu_csr_seq_pkg.sv | 26 ++
 rtl/emu_csr_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_emu_csr_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/emu_csr_seq_pkg.sv
// Shared definitions for the emulator CSR sequencer: command opcodes,
// AXI response codes, FSM states and a counter-width helper.
package emu_csr_seq_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWresp,
    StRaddr,
    StRdata,
    StPwait,
    StResp
  } state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/emu_csr_sequencer.sv
// AXI-Lite master that turns host WRITE/READ/POLL commands into CSR
// transactions and returns exactly one response per accepted command.
module emu_csr_sequencer
  import emu_csr_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned POLL_INTERVAL = 20,
  parameter int unsigned MAX_POLLS     = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_timeout,

  output logic                  m_axilite_awvalid,
  input  logic                  m_axilite_awready,
  output logic [ADDR_WIDTH-1:0] m_axilite_awaddr,
  output logic [2:0]            m_axilite_awprot,

  output logic                  m_axilite_wvalid,
  input  logic                  m_axilite_wready,
  output logic [DATA_WIDTH-1:0] m_axilite_wdata,
  output logic [3:0]            m_axilite_wstrb,

  input  logic                  m_axilite_bvalid,
  output logic                  m_axilite_bready,
  input  logic [1:0]            m_axilite_bresp,

  output logic                  m_axilite_arvalid,
  input  logic                  m_axilite_arready,
  output logic [ADDR_WIDTH-1:0] m_axilite_araddr,
  output logic [2:0]            m_axilite_arprot,

  input  logic                  m_axilite_rvalid,
  output logic                  m_axilite_rready,
  input  logic [DATA_WIDTH-1:0] m_axilite_rdata,
  input  logic [1:0]            m_axilite_rresp
);

  localparam int unsigned PCW = cnt_width(MAX_POLLS);
  localparam int unsigned ICW = cnt_width(POLL_INTERVAL);

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [PCW-1:0]        poll_cnt_q, poll_cnt_d;
  logic [ICW-1:0]        intv_cnt_q, intv_cnt_d;
  // Holds cmd_ready low while in reset and for the first cycle after it.
  logic                  live_q;

  logic                  is_poll;
  logic                  poll_match;
  logic                  rresp_bad;

  assign is_poll    = (op_q == OP_POLL);
  assign poll_match = ((m_axilite_rdata & mask_q) == (data_q & mask_q));
  assign rresp_bad  = (m_axilite_rresp != RESP_OKAY);

  // Next-state and datapath updates for the command sequencer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    poll_cnt_d = poll_cnt_q;
    intv_cnt_d = intv_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && live_q) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          mask_d     = cmd_mask;
          rdata_d    = '0;
          err_d      = 1'b0;
          timeout_d  = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          poll_cnt_d = '0;
          // Reserved opcode falls through to the read path.
          state_d    = (cmd_op == OP_WRITE) ? StWaddr : StRaddr;
        end
      end

      StWaddr: begin
        aw_done_d = aw_done_q | m_axilite_awready;
        w_done_d  = w_done_q | m_axilite_wready;
        if (aw_done_d && w_done_d) begin
          state_d = StWresp;
        end
      end

      StWresp: begin
        if (m_axilite_bvalid) begin
          err_d   = (m_axilite_bresp != RESP_OKAY);
          state_d = StResp;
        end
      end

      StRaddr: begin
        if (m_axilite_arready) begin
          state_d = StRdata;
        end
      end

      StRdata: begin
        if (m_axilite_rvalid) begin
          rdata_d = m_axilite_rdata;
          err_d   = err_q | rresp_bad;
          if (!is_poll) begin
            state_d = StResp;
          end else begin
            poll_cnt_d = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + PCW'(1);
            if (poll_match || rresp_bad) begin
              state_d = StResp;
            end else if ((MAX_POLLS != 0) && (poll_cnt_d == PCW'(MAX_POLLS))) begin
              timeout_d = 1'b1;
              state_d   = StResp;
            end else if (POLL_INTERVAL == 0) begin
              state_d = StRaddr;
            end else begin
              intv_cnt_d = ICW'(POLL_INTERVAL);
              state_d    = StPwait;
            end
          end
        end
      end

      StPwait: begin
        if (intv_cnt_q <= ICW'(1)) begin
          state_d = StRaddr;
        end else begin
          intv_cnt_d = intv_cnt_q - ICW'(1);
        end
      end

      StResp: begin
        if (rsp_ready) begin
          err_d     = 1'b0;
          timeout_d = 1'b0;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      op_q       <= OP_WRITE;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      poll_cnt_q <= '0;
      intv_cnt_q <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      poll_cnt_q <= poll_cnt_d;
      intv_cnt_q <= intv_cnt_d;
      live_q     <= 1'b1;
    end
  end

  // Outputs decode from registered state only, so no valid follows a ready.
  assign cmd_ready         = (state_q == StIdle) && live_q;
  assign m_axilite_awvalid = (state_q == StWaddr) && !aw_done_q;
  assign m_axilite_wvalid  = (state_q == StWaddr) && !w_done_q;
  assign m_axilite_bready  = (state_q == StWresp);
  assign m_axilite_arvalid = (state_q == StRaddr);
  assign m_axilite_rready  = (state_q == StRdata);
  assign rsp_valid         = (state_q == StResp);

  assign m_axilite_awaddr  = addr_q;
  assign m_axilite_araddr  = addr_q;
  assign m_axilite_wdata   = data_q;
  assign m_axilite_wstrb   = 4'hF;
  assign m_axilite_awprot  = 3'b000;
  assign m_axilite_arprot  = 3'b000;

  assign rsp_data          = rdata_q;
  assign rsp_err           = err_q;
  assign rsp_timeout       = timeout_q;

endmodule

// File: tb/tb_emu_csr_sequencer.sv
// Directed bench for emu_csr_sequencer against a behavioural AXI-Lite slave
// with programmable AW/W ready latency, forced read errors and a status
// register whose bit0 sets after a chosen number of reads.
module tb_emu_csr_sequencer;

  localparam int unsigned AW = 12;
  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_STEP = 12'h010;
  localparam logic [11:0] A_STAT = 12'h014;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;

  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  emu_csr_sequencer #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (32),
    .POLL_INTERVAL(20),
    .MAX_POLLS    (8)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_addr         (cmd_addr),
    .cmd_data         (cmd_data),
    .cmd_mask         (cmd_mask),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .rsp_timeout      (rsp_timeout),
    .m_axilite_awvalid(awvalid),
    .m_axilite_awready(awready),
    .m_axilite_awaddr (awaddr),
    .m_axilite_awprot (awprot),
    .m_axilite_wvalid (wvalid),
    .m_axilite_wready (wready),
    .m_axilite_wdata  (wdata),
    .m_axilite_wstrb  (wstrb),
    .m_axilite_bvalid (bvalid),
    .m_axilite_bready (bready),
    .m_axilite_bresp  (bresp),
    .m_axilite_arvalid(arvalid),
    .m_axilite_arready(arready),
    .m_axilite_araddr (araddr),
    .m_axilite_arprot (arprot),
    .m_axilite_rvalid (rvalid),
    .m_axilite_rready (rready),
    .m_axilite_rdata  (rdata),
    .m_axilite_rresp  (rresp)
  );

  always #5 clk = ~clk;

  // Slave configuration, written only by the stimulus process.
  int          aw_lat = 0;
  int          w_lat = 0;
  logic [1:0]  rresp_force = 2'b00;
  int          stat_base = 0;
  int          stat_thresh = 1000;

  // Slave state and handshake statistics.
  logic [31:0] regs [16];
  int          cyc = 0;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [AW-1:0] aw_addr_l;
  logic [31:0] w_data_l;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, split_cnt = 0;
  int          ar_times [256];

  assign awready = awvalid && !aw_got && (aw_cnt >= aw_lat);
  assign wready  = wvalid && !w_got && (w_cnt >= w_lat);
  assign arready = arvalid;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural AXI-Lite slave.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_cnt <= 0;
      w_cnt  <= 0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else begin
      if (awvalid && awready) begin
        aw_got    <= 1'b1;
        aw_addr_l <= awaddr;
        aw_cnt    <= 0;
        aw_hs     <= aw_hs + 1;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_got    <= 1'b1;
        w_data_l <= wdata;
        w_cnt    <= 0;
        w_hs     <= w_hs + 1;
      end else if (wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !bvalid) begin
        regs[aw_addr_l[5:2]] <= w_data_l;
        bvalid <= 1'b1;
        bresp  <= 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_hs   <= b_hs + 1;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rresp  <= rresp_force;
        if (araddr == A_STAT)
          rdata <= ((ar_hs - stat_base + 1) >= stat_thresh) ? 32'h101 : 32'h100;
        else
          rdata <= regs[araddr[5:2]];
        ar_times[ar_hs] <= cyc;
        ar_hs <= ar_hs + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        r_hs   <= r_hs + 1;
      end
      if (awvalid && !wvalid) split_cnt <= split_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [31:0] mask);
    bit got;
    got = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check_eq("cmd_accept", 32'(got), 32'd1);
  endtask

  // Waits for a response, holds rsp_ready low for `hold` cycles watching
  // stability, then consumes it.
  task automatic wait_rsp(input int hold, output logic [31:0] d, output logic e,
                          output logic t, output bit stable);
    bit got;
    got = 1'b0;
    stable = 1'b1;
    d = '0;
    e = 1'b0;
    t = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      d = rsp_data;
      e = rsp_err;
      t = rsp_timeout;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== d || rsp_err !== e || rsp_timeout !== t) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
    check_eq("rsp_seen", 32'(got), 32'd1);
  endtask

  logic [31:0] d;
  logic        e, t;
  bit          st;
  int          aw0, w0, b0, ar0, r0, sp0, min_gap;
  bit          any;

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check_eq("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'h0);
    check_eq("rst_readys", {cmd_ready, bready, rready}, 3'h0);
    check_eq("rst_rsp", {rsp_data, rsp_err, rsp_timeout}, 34'h0);
    check_eq("rst_prot_strb", {awprot, arprot, wstrb}, {6'h0, 4'hF});
    check_eq("rst_addr", {awaddr, araddr}, 24'h0);
    resetn = 1'b1;

    // 1: plain WRITE to an ideal slave, then read it back.
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    send_cmd(2'd0, A_STEP, 32'h3, 32'h0);
    @(negedge clk);
    check_eq("wr_valids", {awvalid, wvalid}, 2'b11);
    check_eq("wr_awaddr", awaddr, A_STEP);
    check_eq("wr_wdata", wdata, 32'h3);
    check_eq("wr_wstrb", wstrb, 4'hF);
    wait_rsp(0, d, e, t, st);
    check_eq("wr_rsp", {d, e, t}, 34'h0);
    check_eq("wr_hs", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
    check_eq("wr_reg", regs[4], 32'h3);
    send_cmd(2'd1, A_STEP, 32'h0, 32'h0);
    wait_rsp(0, d, e, t, st);
    check_eq("rd_rsp", {d, e, t}, {32'h3, 2'b00});

    // 2: W completes three cycles before AW.
    aw_lat = 3; w_lat = 0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; sp0 = split_cnt;
    send_cmd(2'd0, A_CTRL, 32'hDEAD_BEEF, 32'h0);
    wait_rsp(0, d, e, t, st);
    check_eq("split_seen", 32'(split_cnt - sp0 >= 3), 32'd1);
    check_eq("split_hs", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
    check_eq("split_rsp", {d, e, t}, 34'h0);
    check_eq("split_reg", regs[0], 32'hDEAD_BEEF);
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) any = 1'b1;
    end
    check_eq("split_one_rsp", 32'(any), 32'd0);
    aw_lat = 0;

    // 3: POLL matches on the 4th read, reads spaced by the poll interval.
    stat_base = ar_hs; stat_thresh = 4;
    ar0 = ar_hs;
    send_cmd(2'd2, A_STAT, 32'h1, 32'h1);
    wait_rsp(0, d, e, t, st);
    check_eq("poll_reads", ar_hs - ar0, 32'd4);
    min_gap = 1000;
    for (int i = 1; i < 4; i++)
      if (ar_times[ar0 + i] - ar_times[ar0 + i - 1] < min_gap)
        min_gap = ar_times[ar0 + i] - ar_times[ar0 + i - 1];
    check_eq("poll_gap_ge21", 32'(min_gap >= 21), 32'd1);
    check_eq("poll_rsp", {d, e, t}, {32'h101, 2'b00});

    // 4: POLL never matches, times out after MAX_POLLS reads.
    stat_base = ar_hs; stat_thresh = 1000;
    ar0 = ar_hs;
    send_cmd(2'd2, A_STAT, 32'h1, 32'h1);
    wait_rsp(0, d, e, t, st);
    check_eq("tmo_reads", ar_hs - ar0, 32'd8);
    check_eq("tmo_rsp", {d, e, t}, {32'h100, 2'b01});

    // 5: error responses on READ and POLL, then error cleared.
    rresp_force = 2'b10;
    send_cmd(2'd1, A_STEP, 32'h0, 32'h0);
    wait_rsp(0, d, e, t, st);
    check_eq("rderr_rsp", {d, e, t}, {32'h3, 2'b10});
    ar0 = ar_hs;
    send_cmd(2'd2, A_STAT, 32'h1, 32'h1);
    wait_rsp(0, d, e, t, st);
    check_eq("pollerr_reads", ar_hs - ar0, 32'd1);
    check_eq("pollerr_rsp", {e, t}, 2'b10);
    rresp_force = 2'b00;
    send_cmd(2'd3, A_STEP, 32'h0, 32'h0);
    wait_rsp(0, d, e, t, st);
    check_eq("rsvd_rd_rsp", {d, e, t}, {32'h3, 2'b00});

    // 6a: reset while AW/W are pending.
    aw_lat = 10; w_lat = 10;
    send_cmd(2'd0, A_CTRL, 32'h1234, 32'h0);
    @(negedge clk);
    check_eq("pre_rst_valids", {awvalid, wvalid}, 2'b11);
    #2 resetn = 1'b0;
    #1 check_eq("async_rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    aw_lat = 0; w_lat = 0;
    any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) any = 1'b1;
    end
    check_eq("no_rsp_after_rst1", 32'(any), 32'd0);

    // 6b: reset during the poll wait.
    stat_base = ar_hs; stat_thresh = 1000;
    r0 = r_hs;
    send_cmd(2'd2, A_STAT, 32'h1, 32'h1);
    for (int i = 0; i < 50 && r_hs == r0; i++) @(negedge clk);
    check_eq("pwait_r_seen", 32'(r_hs - r0), 32'd1);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_eq("pwait_rst_outs", {arvalid, rsp_valid, cmd_ready}, 3'b000);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    ar0 = ar_hs;
    any = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) any = 1'b1;
    end
    check_eq("no_rsp_after_rst2", 32'(any), 32'd0);
    check_eq("no_ar_after_rst2", ar_hs - ar0, 32'd0);

    // 6c: next command completes normally with a stalled response.
    send_cmd(2'd0, A_STEP, 32'h7, 32'h0);
    wait_rsp(5, d, e, t, st);
    check_eq("post_rst_stable", 32'(st), 32'd1);
    check_eq("post_rst_rsp", {d, e, t}, 34'h0);
    check_eq("post_rst_reg", regs[4], 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
